// File: rtl/next_addr_pkg.sv
// Shared constants for the fetch next-address generator: redirect-mode
// encodings on the sel port and the trap vector stride.
package next_addr_pkg;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JMP  = 2'b10;
  localparam logic [1:0] SEL_TRAP = 2'b11;

  // Each trap vector owns 4 words, so tt is scaled by a 2-bit left shift.
  localparam int TRAP_STRIDE      = 4;
  localparam int TRAP_STRIDE_LOG2 = 2;

endpackage

// File: rtl/next_addr_gen_addr_adder.sv
// AW-wide modular adder (a + b + cin). It is used both as the npc incrementer
// and as the pc-relative branch target adder.
module addr_adder #(
  parameter int W = 30
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  // Carry out is dropped on purpose: address arithmetic wraps silently.
  assign sum = a + b + W'(cin);

endmodule

// File: rtl/next_addr_gen.sv
// Fetch-stage next-address generator. It holds the architectural pc/npc pair
// with one delay slot and an annul flag, and advances it under the fetch
// handshake. All outputs come straight from registers.
// Optional feature macro: NEXT_ADDR_TRAP_EN enables trap redirection (sel=11)
// and the trap_pc capture register. Without it, sel=11 behaves as a
// sequential step and trap_pc reads as zero.
module next_addr_gen
  import next_addr_pkg::*;
#(
  parameter int            AW         = 30,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter logic [AW-1:0] TRAP_BASE  = AW'('h100)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance,
  input  logic [1:0]           sel,
  input  logic                 taken,
  input  logic                 annul,
  input  logic signed [AW-1:0] disp,
  input  logic [AW-1:0]        target,
  input  logic [7:0]           tt,
  output logic [AW-1:0]        pc,
  output logic [AW-1:0]        npc,
  output logic                 pc_valid,
  output logic                 slot_annul,
  output logic [AW-1:0]        trap_pc
);

  localparam logic [AW-1:0] RESET_NPC = RESET_ADDR + AW'(1);

  logic [AW-1:0] pc_q, npc_q;
  logic          pc_valid_q, slot_annul_q;
  logic [AW-1:0] pc_d, npc_d;
  logic          slot_annul_d;
  logic [AW-1:0] npc_inc, br_target;
  logic          is_trap;
  logic          redirect;

  addr_adder #(.W(AW)) u_npc_inc (
    .a   (npc_q),
    .b   ('0),
    .cin (1'b1),
    .sum (npc_inc)
  );

  addr_adder #(.W(AW)) u_br_target (
    .a   (pc_q),
    .b   (disp),
    .cin (1'b0),
    .sum (br_target)
  );

`ifdef NEXT_ADDR_TRAP_EN
  logic [AW-1:0] trap_pc_q, trap_pc_d;
  logic [AW-1:0] trap_vec, trap_vec_inc;

  assign is_trap      = (sel == SEL_TRAP);
  assign trap_vec     = TRAP_BASE + (AW'(tt) << TRAP_STRIDE_LOG2);
  assign trap_vec_inc = trap_vec + AW'(1);
  assign trap_pc      = trap_pc_q;
`else
  logic trap_unused;

  assign is_trap     = 1'b0;
  assign trap_unused = ^{tt, TRAP_BASE};
  assign trap_pc     = '0;
`endif

  // Only a taken branch or jump replaces the sequential npc successor.
  assign redirect = taken && ((sel == SEL_BR) || (sel == SEL_JMP));

  // Next-state selection: a trap flushes regardless of advance; otherwise the
  // pair moves only when fetch consumes pc.
  always_comb begin
    pc_d         = pc_q;
    npc_d        = npc_q;
    slot_annul_d = slot_annul_q;
`ifdef NEXT_ADDR_TRAP_EN
    trap_pc_d    = trap_pc_q;
`endif
    if (is_trap) begin
`ifdef NEXT_ADDR_TRAP_EN
      pc_d         = trap_vec;
      npc_d        = trap_vec_inc;
      trap_pc_d    = pc_q;
`endif
      slot_annul_d = 1'b0;
    end else if (advance) begin
      pc_d = npc_q;
      if (redirect) begin
        npc_d        = (sel == SEL_BR) ? br_target : target;
        slot_annul_d = annul;
      end else begin
        npc_d        = npc_inc;
        slot_annul_d = 1'b0;
      end
    end
  end

  // Architectural state; reset overrides any in-flight redirect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_ADDR;
      npc_q        <= RESET_NPC;
      pc_valid_q   <= 1'b0;
      slot_annul_q <= 1'b0;
`ifdef NEXT_ADDR_TRAP_EN
      trap_pc_q    <= '0;
`endif
    end else begin
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      pc_valid_q   <= 1'b1;
      slot_annul_q <= slot_annul_d;
`ifdef NEXT_ADDR_TRAP_EN
      trap_pc_q    <= trap_pc_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign npc        = npc_q;
  assign pc_valid   = pc_valid_q;
  assign slot_annul = slot_annul_q;

endmodule
